cbus_arbiter: RTL and testbench

Shares the single cache bus (cbus_req_t / cbus_resp_t burst interface toward the AXI bridge) between NUM_PORTS cache masters, typically ICache (port 0) and DCache (port 1). A transaction is granted whole: once a port wins, its burst owns the downstream bus until the beat flagged `last` completes. Sits between the caches and the AXI adapter in the core top level.

---
 rtl/cbus_arbiter_pkg.sv | 48 ++++
 rtl/cbus_arbiter_if.sv | 36 +++
 rtl/cbus_arb_picker.sv | 46 ++++
 rtl/cbus_arbiter.sv | 107 ++++++++++
 tb/tb_cbus_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cbus_arbiter_pkg.sv
// Shared types for the cache-bus arbiter.
// Cache bus request/response bundles and arbiter FSM states.
package cbus_arbiter_pkg;

  parameter int CBUS_ARB_PORTS = 2;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

  // Burst length encoded as beats-1
  typedef enum logic [7:0] {
    MLEN1  = 8'd0,
    MLEN2  = 8'd1,
    MLEN4  = 8'd3,
    MLEN8  = 8'd7,
    MLEN16 = 8'd15
  } mlen_t;

  typedef enum logic [1:0] {
    AXI_FIXED = 2'd0,
    AXI_INCR  = 2'd1,
    AXI_WRAP  = 2'd2
  } axi_burst_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [63:0] addr;
    logic [2:0]  size;
    mlen_t       len;
    axi_burst_t  burst;
    logic [7:0]  strobe;
    logic [63:0] data;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cbus_arbiter_if.sv
// Cache-bus arbiter port bundle.
// Upstream per-port req/resp, downstream req/resp, debug status.
interface cbus_arbiter_if
  import cbus_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = CBUS_ARB_PORTS
) ();

  localparam int IW = idx_w(NUM_PORTS);

  cbus_req_t     ireqs  [NUM_PORTS];
  cbus_resp_t    iresps [NUM_PORTS];
  cbus_req_t     oreq;
  cbus_resp_t    oresp;
  logic [IW-1:0] grant_idx;
  logic          busy;

  modport slave (
    input  ireqs,
    input  oresp,
    output iresps,
    output oreq,
    output grant_idx,
    output busy
  );

  modport master (
    output ireqs,
    output oresp,
    input  iresps,
    input  oreq,
    input  grant_idx,
    input  busy
  );

endinterface

// File: rtl/cbus_arb_picker.sv
// Winner selection for the cache-bus arbiter.
// CBUS_ARB_RR_EN: round-robin from ptr, else lowest index.
module cbus_arb_picker
  import cbus_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = CBUS_ARB_PORTS,
  localparam int IW = idx_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] valid,
  input  logic [IW-1:0]        ptr,
  output logic [IW-1:0]        winner,
  output logic                 any_valid
);

  assign any_valid = |valid;

`ifdef CBUS_ARB_RR_EN
  // First valid port scanning upward from ptr, wrapping
  always_comb begin
    logic found;
    int   j;
    winner = '0;
    found  = 1'b0;
    j      = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      j = (int'(ptr) + k) % NUM_PORTS;
      if (!found && valid[j]) begin
        winner = IW'(j);
        found  = 1'b1;
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Lowest valid index wins
  always_comb begin
    winner = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (valid[k]) winner = IW'(k);
    end
  end
`endif

endmodule

// File: rtl/cbus_arbiter.sv
// Cache-bus arbiter: whole-burst grants of N masters onto one bus.
// Macro CBUS_ARB_RR_EN selects round-robin instead of fixed priority.
module cbus_arbiter
  import cbus_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = CBUS_ARB_PORTS
) (
  input  logic         clk,
  input  logic         reset,
  cbus_arbiter_if.slave bus
);

  localparam int IW = idx_w(NUM_PORTS);

  arb_state_t           state_q;
  arb_state_t           state_d;
  logic [IW-1:0]        owner_q;
  logic [IW-1:0]        winner;
  logic [IW-1:0]        ptr;
  logic [NUM_PORTS-1:0] valid_vec;
  logic                 any_valid;
  logic                 grant;
  logic                 done;

  // Gather per-port request valids
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      valid_vec[i] = bus.ireqs[i].valid;
    end
  end

  cbus_arb_picker #(
    .NUM_PORTS(NUM_PORTS)
  ) u_picker (
    .valid    (valid_vec),
    .ptr      (ptr),
    .winner   (winner),
    .any_valid(any_valid)
  );

  assign grant = (state_q == ARB_IDLE) && any_valid;
  assign done  = (state_q == ARB_BUSY)
               && bus.oresp.ready
               && bus.oresp.last;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ARB_IDLE;
    else       state_q <= state_d;
  end

  // Next state: grant on any request, release on last beat
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: if (any_valid) state_d = ARB_BUSY;
      ARB_BUSY: if (done)      state_d = ARB_IDLE;
      default:                 state_d = ARB_IDLE;
    endcase
  end

  // Owner latched on grant, held through the burst
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      owner_q <= '0;
    else if (grant) owner_q <= winner;
  end

`ifdef CBUS_ARB_RR_EN
  logic [IW-1:0] ptr_q;

  // Next search start is one past the latest winner
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (grant) begin
      if (int'(winner) == NUM_PORTS - 1)
        ptr_q <= '0;
      else
        ptr_q <= winner + 1'b1;
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  // Owner's request out, bus response back to owner only
  always_comb begin
    bus.oreq = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      bus.iresps[i] = '0;
    end
    if (state_q == ARB_BUSY) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (owner_q == IW'(i)) begin
          bus.oreq      = bus.ireqs[i];
          bus.iresps[i] = bus.oresp;
        end
      end
    end
  end

  assign bus.busy      = (state_q == ARB_BUSY);
  assign bus.grant_idx = owner_q;

endmodule

// File: tb/tb_cbus_arbiter.sv
// Bench for cbus_arbiter: vector table, directed bursts, random traffic.
// Reference model tracks owner/pointer as plain integers.
module tb_cbus_arbiter;
  import cbus_arbiter_pkg::*;

  localparam int N = CBUS_ARB_PORTS;

  typedef struct {
    bit v0, v1, rdy, lst;
    bit e_busy;
    int e_g;
    bit e_ov, e_r0, e_r1;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  cbus_req_t  req [N];
  cbus_resp_t rsp;

  int vecs = 0;
  int errs = 0;
  int m_owner, m_grant, m_last, m_beat;
  int done_port, acc_port, gnt_port;
  bit o_busy, o_ov, o_r0, o_r1;
  int o_g;
  int hist_busy[$];
  int hist_g[$];
  int hist_ov[$];

  always #5 clk = ~clk;

  cbus_arbiter_if #(.NUM_PORTS(N)) bus ();

  assign bus.ireqs = req;
  assign bus.oresp = rsp;

  cbus_arbiter #(.NUM_PORTS(N)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic chk(string nm, logic [150:0] act,
                     logic [150:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_owner = -1;
    m_grant = 0;
    m_last  = N - 1;
    m_beat  = 0;
  endfunction

  function automatic int pick();
    int s;
`ifdef CBUS_ARB_RR_EN
    s = (m_last + 1) % N;
`else
    s = 0;
`endif
    for (int k = 0; k < N; k++) begin
      if (req[(s + k) % N].valid) return (s + k) % N;
    end
    return -1;
  endfunction

  function automatic int beats(mlen_t l);
    return int'(l) + 1;
  endfunction

  function automatic void new_txn(int p, bit wr,
                                  logic [63:0] a, mlen_t l);
    req[p]          = '0;
    req[p].valid    = 1'b1;
    req[p].is_write = wr;
    req[p].addr     = a;
    req[p].size     = 3'd3;
    req[p].len      = l;
    req[p].burst    = AXI_INCR;
    if (wr) begin
      req[p].strobe = 8'($urandom);
      req[p].data   = {$urandom, $urandom};
    end
  endfunction

  function automatic void drive_adapter(bit rnd);
    rsp = '0;
    if (m_owner >= 0) begin
      rsp.ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      rsp.last  = rsp.ready &&
                  (m_beat == beats(req[m_owner].len) - 1);
      rsp.data  = {$urandom, $urandom};
    end else if (rnd) begin
      rsp.ready = 1'($urandom_range(0, 1));
      rsp.last  = 1'($urandom_range(0, 1));
      rsp.data  = {$urandom, $urandom};
    end
  endfunction

  task automatic check_model();
    cbus_req_t  eq;
    cbus_resp_t er;
    eq = '0;
    if (m_owner >= 0) eq = req[m_owner];
    chk("oreq", 151'(bus.oreq), 151'(eq));
    for (int i = 0; i < N; i++) begin
      er = '0;
      if (m_owner == i) er = rsp;
      chk($sformatf("iresps[%0d]", i),
          151'(bus.iresps[i]), 151'(er));
    end
    chk("busy", 151'(bus.busy), 151'(m_owner >= 0));
    chk("grant_idx", 151'(bus.grant_idx), 151'(m_grant));
  endtask

  task automatic cycle();
    int w;
    @(negedge clk);
    check_model();
    o_busy = bus.busy;
    o_g    = int'(bus.grant_idx);
    o_ov   = bus.oreq.valid;
    o_r0   = bus.iresps[0].ready;
    o_r1   = bus.iresps[1].ready;
    hist_busy.push_back(int'(o_busy));
    hist_g.push_back(o_g);
    hist_ov.push_back(int'(o_ov));
    @(posedge clk);
    #1;
    done_port = -1;
    acc_port  = -1;
    gnt_port  = -1;
    if (m_owner < 0) begin
      w = pick();
      if (w >= 0) begin
        m_owner  = w;
        m_grant  = w;
        m_last   = w;
        m_beat   = 0;
        gnt_port = w;
      end
    end else if (rsp.ready) begin
      acc_port = m_owner;
      m_beat++;
      if (rsp.last) begin
        done_port = m_owner;
        m_owner   = -1;
      end
    end
  endtask

  function automatic void after_cycle(bit rnd, bit rereq);
    mlen_t lens [4];
    lens = '{MLEN1, MLEN2, MLEN4, MLEN8};
    if (acc_port >= 0 && done_port < 0 &&
        req[acc_port].is_write) begin
      req[acc_port].data   = {$urandom, $urandom};
      req[acc_port].strobe = 8'($urandom);
    end
    if (done_port >= 0) begin
      if (rereq)
        new_txn(done_port, 1'b0,
                64'(32'h1000 * (done_port + 1)), MLEN2);
      else
        req[done_port] = '0;
    end
    if (rnd) begin
      for (int p = 0; p < N; p++) begin
        if (!req[p].valid && $urandom_range(0, 2) == 0)
          new_txn(p, 1'($urandom_range(0, 1)),
                  {32'h8000_0000, $urandom & 32'hFFC0},
                  lens[$urandom_range(0, 3)]);
      end
    end
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int p = 0; p < N; p++) req[p] = '0;
    rsp = '0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    hist_busy.delete();
    hist_g.delete();
    hist_ov.delete();
  endtask

  initial begin
    vec_t tbl [12];
    int   n;
    int   e0;
    int   r1;
    int   ng;
    bit   fin;
    int   order [4];
    int   exp_order [4];
    int   exp_busy [6];

    reset = 1'b1;
    for (int p = 0; p < N; p++) req[p] = '0;
    rsp = '0;
    model_reset();
    #1;
    check_model();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // v0 v1 rdy lst | busy g ov r0 r1
    tbl[0]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 1, 0, 1, 0, 1, 1, 0};
    tbl[2]  = '{1, 1, 1, 1, 1, 0, 1, 1, 0};
    tbl[3]  = '{0, 1, 1, 1, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 1, 1, 1, 1, 1, 1, 0, 1};
    tbl[5]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
    tbl[6]  = '{1, 0, 0, 0, 0, 1, 0, 0, 0};
    tbl[7]  = '{1, 1, 0, 0, 1, 0, 1, 0, 0};
    tbl[8]  = '{1, 1, 1, 1, 1, 0, 1, 1, 0};
    tbl[9]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[10] = '{0, 1, 1, 1, 1, 1, 1, 0, 1};
    tbl[11] = '{0, 0, 0, 0, 0, 1, 0, 0, 0};

    new_txn(0, 1'b0, 64'h100, MLEN1);
    new_txn(1, 1'b0, 64'h200, MLEN1);
    for (int i = 0; i < 12; i++) begin
      req[0].valid = tbl[i].v0;
      req[1].valid = tbl[i].v1;
      rsp       = '0;
      rsp.ready = tbl[i].rdy;
      rsp.last  = tbl[i].lst;
      rsp.data  = 64'hD0 + 64'(i);
      cycle();
      chk($sformatf("tbl%0d.busy", i), 151'(o_busy),
          151'(tbl[i].e_busy));
      chk($sformatf("tbl%0d.grant", i), 151'(o_g),
          151'(tbl[i].e_g));
      chk($sformatf("tbl%0d.ovalid", i), 151'(o_ov),
          151'(tbl[i].e_ov));
      chk($sformatf("tbl%0d.r0", i), 151'(o_r0),
          151'(tbl[i].e_r0));
      chk($sformatf("tbl%0d.r1", i), 151'(o_r1),
          151'(tbl[i].e_r1));
    end

    // single requester, MLEN8 read on port 1
    do_reset();
    new_txn(1, 1'b0, 64'h8000_0040, MLEN8);
    n   = 0;
    fin = 1'b0;
    for (int c = 0; c < 40 && !fin; c++) begin
      drive_adapter(1'b0);
      cycle();
      if (acc_port == 1) n++;
      if (done_port == 1) fin = 1'b1;
      after_cycle(1'b0, 1'b0);
    end
    chk("single.done", 151'(fin), 151'(1));
    chk("single.beats", 151'(n), 151'(8));
    rsp = '0;
    cycle();
    chk("single.valid_drop", 151'(o_ov), 151'(0));

    // reset during beat 3 of an MLEN8 read on port 1
    do_reset();
    new_txn(1, 1'b0, 64'h8000_0080, MLEN8);
    n = 0;
    for (int c = 0; c < 20 && n < 2; c++) begin
      drive_adapter(1'b0);
      cycle();
      if (acc_port == 1) n++;
      after_cycle(1'b0, 1'b0);
    end
    drive_adapter(1'b0);
    #2;
    chk("rst.pre_grant", 151'(bus.grant_idx), 151'(1));
    reset = 1'b1;
    #1;
    chk("rst.ovalid", 151'(bus.oreq.valid), 151'(0));
    chk("rst.iresp0", 151'(bus.iresps[0]), 151'(0));
    chk("rst.iresp1", 151'(bus.iresps[1]), 151'(0));
    chk("rst.busy", 151'(bus.busy), 151'(0));
    req[1] = '0;
    rsp    = '0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle();
    chk("rst.idle", 151'(o_busy), 151'(0));
    chk("rst.grant0", 151'(o_g), 151'(0));

    // write burst, data/strobe change on each accepted beat
    do_reset();
    new_txn(1, 1'b1, 64'h8000_1000, MLEN4);
    n   = 0;
    fin = 1'b0;
    for (int c = 0; c < 80 && !fin; c++) begin
      drive_adapter(1'b1);
      cycle();
      if (acc_port == 1) n++;
      if (done_port == 1) fin = 1'b1;
      after_cycle(1'b0, 1'b0);
    end
    chk("wr.done", 151'(fin), 151'(1));
    chk("wr.beats", 151'(n), 151'(4));

    // simultaneous requests after reset: port 0 first,
    // port 1 drives two cycles after port 0's last beat
    do_reset();
    new_txn(0, 1'b0, 64'h100, MLEN4);
    new_txn(1, 1'b0, 64'h200, MLEN2);
    e0 = -100;
    r1 = -1;
    ng = -1;
    for (int c = 0; c < 14; c++) begin
      drive_adapter(1'b0);
      cycle();
      if (r1 < 0 && o_ov && o_g == 1) r1 = c;
      if (ng < 0 && gnt_port >= 0) ng = gnt_port;
      if (done_port == 0) e0 = c;
      after_cycle(1'b0, 1'b0);
    end
    chk("simul.first", 151'(ng), 151'(0));
    chk("simul.gap", 151'(r1 - e0), 151'(2));

    // continuous requests on both ports: grant order
    do_reset();
    new_txn(0, 1'b0, 64'h1000, MLEN2);
    new_txn(1, 1'b0, 64'h2000, MLEN2);
`ifdef CBUS_ARB_RR_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    order = '{-1, -1, -1, -1};
    ng    = 0;
    for (int c = 0; c < 60 && ng < 4; c++) begin
      drive_adapter(1'b0);
      cycle();
      if (gnt_port >= 0) begin
        order[ng] = gnt_port;
        ng++;
      end
      after_cycle(1'b0, 1'b1);
    end
    for (int i = 0; i < 4; i++)
      chk($sformatf("order%0d", i), 151'(order[i]),
          151'(exp_order[i]));

    // single-beat transactions back to back
    do_reset();
    new_txn(0, 1'b0, 64'h300, MLEN1);
    new_txn(1, 1'b0, 64'h400, MLEN1);
    exp_busy = '{0, 1, 0, 1, 0, 0};
    for (int c = 0; c < 6; c++) begin
      drive_adapter(1'b0);
      cycle();
      after_cycle(1'b0, 1'b0);
    end
    for (int i = 0; i < 6; i++)
      chk($sformatf("mlen1.busy%0d", i), 151'(hist_busy[i]),
          151'(exp_busy[i]));
    chk("mlen1.second_grant", 151'(hist_g[3]), 151'(1));
    chk("mlen1.second_valid", 151'(hist_ov[3]), 151'(1));

    // random traffic against the model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      drive_adapter(1'b1);
      cycle();
      after_cycle(1'b1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
